// File: rtl/mips_pkg.sv
// Shared widths, ALU opcodes, multiplier FSM states and the EX/MEM record
// used by the MIPS execute stage.
package mips_pkg;

    localparam int NB_ADDR   = 5;
    localparam int NB_DATA   = 2**NB_ADDR;
    localparam int NB_ALU_OP = 4;

    // One spare bit so the iteration index never wraps before it is compared.
    localparam int MUL_CNT_W = NB_ADDR + 1;

    localparam logic [NB_ALU_OP-1:0] ALU_ADD = 4'd0;
    localparam logic [NB_ALU_OP-1:0] ALU_SUB = 4'd1;
    localparam logic [NB_ALU_OP-1:0] ALU_AND = 4'd2;
    localparam logic [NB_ALU_OP-1:0] ALU_OR  = 4'd3;
    localparam logic [NB_ALU_OP-1:0] ALU_XOR = 4'd4;
    localparam logic [NB_ALU_OP-1:0] ALU_NOR = 4'd5;
    localparam logic [NB_ALU_OP-1:0] ALU_SLT = 4'd6;
    localparam logic [NB_ALU_OP-1:0] ALU_SLL = 4'd7;
    localparam logic [NB_ALU_OP-1:0] ALU_SRL = 4'd8;
    localparam logic [NB_ALU_OP-1:0] ALU_SRA = 4'd9;
    localparam logic [NB_ALU_OP-1:0] ALU_LUI = 4'd10;
    localparam logic [NB_ALU_OP-1:0] ALU_MUL = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_RUN  = 2'd1,
        ST_MUL_DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic [NB_DATA-1:0] alu_result;
        logic [NB_DATA-1:0] rf_data;
        logic               alu_zero;
        logic [NB_DATA-1:0] branch_addr;
        logic               mem_wr_enb;
        logic               mem_rd_enb;
        logic               is_branch;
        logic               rf_wr_enb;
        logic               rf_wr_data_src;
        logic [NB_ADDR-1:0] rf_wr_addr;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '0;

endpackage

// File: rtl/execute_unit_if.sv
// Signal bundle between the ID/EX register, the execute stage and the
// EX/MEM register.
interface execute_unit_if
    import mips_pkg::*;
();
    // Handshake: an instruction with i_valid=1 is consumed on the edge it is
    // presented while the stage is idle. o_busy=1 means upstream must hold
    // PC, IF/ID and ID/EX unchanged; it is raised already in the MUL issue
    // cycle so the MUL stays parked in ID/EX until its result is ready.
    logic                 i_valid;
    logic                 i_flush;
    logic [NB_DATA-1:0]   i_rs_data;
    logic [NB_DATA-1:0]   i_rt_data;
    logic [NB_DATA-1:0]   i_imm;
    logic [4:0]           i_shamt;
    logic [NB_DATA-1:0]   i_pc_plus4;
    logic [NB_ALU_OP-1:0] i_alu_op;
    logic                 i_alu_src;
    logic                 i_mem_wr_enb;
    logic                 i_mem_rd_enb;
    logic                 i_is_branch;
    logic                 i_rf_wr_enb;
    logic                 i_rf_wr_data_src;
    logic [NB_ADDR-1:0]   i_rf_wr_addr;

    logic                 o_busy;
    logic [NB_DATA-1:0]   o_alu_result;
    logic [NB_DATA-1:0]   o_rf_data;
    logic                 o_alu_zero;
    logic [NB_DATA-1:0]   o_branch_addr;
    logic                 o_mem_wr_enb;
    logic                 o_mem_rd_enb;
    logic                 o_is_branch;
    logic                 o_rf_wr_enb;
    logic                 o_rf_wr_data_src;
    logic [NB_ADDR-1:0]   o_rf_wr_addr;
    mul_state_t           o_dbg_state;

    modport master (
        output i_valid, i_flush, i_rs_data, i_rt_data, i_imm, i_shamt,
               i_pc_plus4, i_alu_op, i_alu_src, i_mem_wr_enb, i_mem_rd_enb,
               i_is_branch, i_rf_wr_enb, i_rf_wr_data_src, i_rf_wr_addr,
        input  o_busy, o_alu_result, o_rf_data, o_alu_zero, o_branch_addr,
               o_mem_wr_enb, o_mem_rd_enb, o_is_branch, o_rf_wr_enb,
               o_rf_wr_data_src, o_rf_wr_addr, o_dbg_state
    );

    modport slave (
        input  i_valid, i_flush, i_rs_data, i_rt_data, i_imm, i_shamt,
               i_pc_plus4, i_alu_op, i_alu_src, i_mem_wr_enb, i_mem_rd_enb,
               i_is_branch, i_rf_wr_enb, i_rf_wr_data_src, i_rf_wr_addr,
        output o_busy, o_alu_result, o_rf_data, o_alu_zero, o_branch_addr,
               o_mem_wr_enb, o_mem_rd_enb, o_is_branch, o_rf_wr_enb,
               o_rf_wr_data_src, o_rf_wr_addr, o_dbg_state
    );

endinterface

// File: rtl/iterative_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per cycle over NB_DATA
// cycles, then a single DONE cycle that presents the low word of the product.
module iterative_multiplier
    import mips_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_multiplicand,
    input  logic [NB_DATA-1:0] i_multiplier,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_result,
    output mul_state_t         o_state
);

    localparam logic [MUL_CNT_W-1:0] LAST_ITER = MUL_CNT_W'(NB_DATA - 1);

    mul_state_t           state_q;
    mul_state_t           state_d;
    logic [MUL_CNT_W-1:0] cnt_q;
    logic [NB_DATA-1:0]   mcand_q;
    logic [NB_DATA-1:0]   mplier_q;
    logic [NB_DATA-1:0]   acc_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_MUL_RUN;
                end
            end
            ST_MUL_RUN: begin
                o_busy = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_MUL_DONE;
                end
            end
            ST_MUL_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush abandons any multiply, including one about to start.
        if (i_flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if ((state_q == ST_IDLE) && i_start && !i_flush) begin
            cnt_q    <= '0;
            mcand_q  <= i_multiplicand;
            mplier_q <= i_multiplier;
            acc_q    <= '0;
        end else if (state_q == ST_MUL_RUN) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + MUL_CNT_W'(1);
        end
    end

    assign o_result = acc_q;
    assign o_state  = state_q;

endmodule

// File: rtl/execute_unit.sv
// MIPS EX stage: combinational ALU, iterative multiplier and the EX/MEM
// pipeline register feeding the memory access stage.
module execute_unit
    import mips_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_reset_n,
    execute_unit_if.slave bus
);

    logic [NB_DATA-1:0] op_b;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_DATA-1:0] mul_result;
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    mul_state_t         mul_state;
    ex_mem_t            cur;
    ex_mem_t            held_q;
    ex_mem_t            ex_mem_d;
    ex_mem_t            ex_mem_q;

    always_comb begin
        op_b       = bus.i_alu_src ? bus.i_imm : bus.i_rt_data;
        alu_result = '0;
        case (bus.i_alu_op)
            ALU_ADD: alu_result = bus.i_rs_data + op_b;
            ALU_SUB: alu_result = bus.i_rs_data - op_b;
            ALU_AND: alu_result = bus.i_rs_data & op_b;
            ALU_OR:  alu_result = bus.i_rs_data | op_b;
            ALU_XOR: alu_result = bus.i_rs_data ^ op_b;
            ALU_NOR: alu_result = ~(bus.i_rs_data | op_b);
            ALU_SLT: alu_result = {{(NB_DATA-1){1'b0}},
                                   ($signed(bus.i_rs_data) < $signed(op_b))};
            ALU_SLL: alu_result = op_b << bus.i_shamt;
            ALU_SRL: alu_result = op_b >> bus.i_shamt;
            ALU_SRA: alu_result = $unsigned($signed(op_b) >>> bus.i_shamt);
            ALU_LUI: alu_result = {op_b[NB_DATA-17:0], 16'h0000};
            default: alu_result = '0;
        endcase
    end

    assign is_mul    = (bus.i_alu_op == ALU_MUL);
    assign mul_start = bus.i_valid && is_mul && (mul_state == ST_IDLE) && !bus.i_flush;

    iterative_multiplier u_mult (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .i_start        (mul_start),
        .i_flush        (bus.i_flush),
        .i_multiplicand (bus.i_rs_data),
        .i_multiplier   (op_b),
        .o_busy         (mul_busy),
        .o_done         (mul_done),
        .o_result       (mul_result),
        .o_state        (mul_state)
    );

    // Everything the current instruction would write into EX/MEM; for a MUL
    // this is parked in held_q and the result field is patched at DONE.
    always_comb begin
        cur                = EX_MEM_BUBBLE;
        cur.alu_result     = alu_result;
        cur.rf_data        = bus.i_rt_data;
        cur.alu_zero       = (alu_result == '0);
        cur.branch_addr    = bus.i_pc_plus4 + {bus.i_imm[NB_DATA-3:0], 2'b00};
        cur.mem_wr_enb     = bus.i_mem_wr_enb;
        cur.mem_rd_enb     = bus.i_mem_rd_enb;
        cur.is_branch      = bus.i_is_branch;
        cur.rf_wr_enb      = bus.i_rf_wr_enb;
        cur.rf_wr_data_src = bus.i_rf_wr_data_src;
        cur.rf_wr_addr     = bus.i_rf_wr_addr;
    end

    always_comb begin
        ex_mem_d = EX_MEM_BUBBLE;
        if (bus.i_flush) begin
            ex_mem_d = EX_MEM_BUBBLE;
        end else if (mul_done) begin
            ex_mem_d            = held_q;
            ex_mem_d.alu_result = mul_result;
            ex_mem_d.alu_zero   = (mul_result == '0);
        end else if ((mul_state == ST_IDLE) && bus.i_valid && !is_mul) begin
            ex_mem_d = cur;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ex_mem_q <= EX_MEM_BUBBLE;
            held_q   <= EX_MEM_BUBBLE;
        end else begin
            ex_mem_q <= ex_mem_d;
            if (mul_start) begin
                held_q <= cur;
            end
        end
    end

    // Reset gating keeps o_busy low while the ID/EX register still holds a MUL.
    assign bus.o_busy           = i_reset_n && (mul_start || mul_busy);
    assign bus.o_alu_result     = ex_mem_q.alu_result;
    assign bus.o_rf_data        = ex_mem_q.rf_data;
    assign bus.o_alu_zero       = ex_mem_q.alu_zero;
    assign bus.o_branch_addr    = ex_mem_q.branch_addr;
    assign bus.o_mem_wr_enb     = ex_mem_q.mem_wr_enb;
    assign bus.o_mem_rd_enb     = ex_mem_q.mem_rd_enb;
    assign bus.o_is_branch      = ex_mem_q.is_branch;
    assign bus.o_rf_wr_enb      = ex_mem_q.rf_wr_enb;
    assign bus.o_rf_wr_data_src = ex_mem_q.rf_wr_data_src;
    assign bus.o_rf_wr_addr     = ex_mem_q.rf_wr_addr;
    assign bus.o_dbg_state      = mul_state;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed cases with literal results
// plus randomized traffic compared every cycle against a cycle-count model.
module tb_execute_unit;
  import mips_pkg::*;

  logic i_clock = 1'b0;
  logic i_reset_n;
  always #5 i_clock = ~i_clock;

  execute_unit_if bus();

  execute_unit dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] rf_data;
    logic        zero;
    logic [31:0] br;
    logic [4:0]  ctrl;   // {mem_wr, mem_rd, is_branch, rf_wr, rf_src}
    logic [4:0]  waddr;
  } exp_t;

  exp_t        exp_now  = '0;
  exp_t        mul_meta = '0;
  logic [31:0] exp_q[$];
  int          mul_left = 0;   // edges still to go until a MUL result lands

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = b << sh;
      4'd8:  r = b >> sh;
      4'd9:  r = $unsigned($signed(b) >>> sh);
      4'd10: r = b * 32'd65536;
      4'd11: r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic exp_t snapshot();
    exp_t        e;
    logic [31:0] b;
    b         = bus.i_alu_src ? bus.i_imm : bus.i_rt_data;
    e.res     = ref_alu(bus.i_alu_op, bus.i_rs_data, b, bus.i_shamt);
    e.rf_data = bus.i_rt_data;
    e.zero    = (e.res == 32'd0);
    e.br      = bus.i_pc_plus4 + bus.i_imm * 32'd4;
    e.ctrl    = {bus.i_mem_wr_enb, bus.i_mem_rd_enb, bus.i_is_branch,
                 bus.i_rf_wr_enb, bus.i_rf_wr_data_src};
    e.waddr   = bus.i_rf_wr_addr;
    return e;
  endfunction

  always @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      exp_now  = '0;
      mul_left = 0;
      exp_q.delete();
    end else if (bus.i_flush) begin
      exp_now  = '0;
      mul_left = 0;
      exp_q.delete();
    end else if (mul_left > 0) begin
      mul_left--;
      exp_now = '0;
      if (mul_left == 0 && exp_q.size() > 0) begin
        exp_now      = mul_meta;
        exp_now.res  = exp_q.pop_front();
        exp_now.zero = (exp_now.res == 32'd0);
      end
    end else if (bus.i_valid && bus.i_alu_op == 4'd11) begin
      mul_meta = snapshot();
      exp_q.push_back(mul_meta.res);
      mul_left = 33;
      exp_now  = '0;
    end else if (bus.i_valid) begin
      exp_now = snapshot();
    end else begin
      exp_now = '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clock) begin
    logic exp_busy;
    exp_busy = i_reset_n && ((mul_left > 1) ||
               (mul_left == 0 && bus.i_valid && bus.i_alu_op == 4'd11 && !bus.i_flush));
    check("busy",        bus.o_busy,           exp_busy);
    check("alu_result",  bus.o_alu_result,     exp_now.res);
    check("rf_data",     bus.o_rf_data,        exp_now.rf_data);
    check("alu_zero",    bus.o_alu_zero,       exp_now.zero);
    check("branch_addr", bus.o_branch_addr,    exp_now.br);
    check("ctrl",        {bus.o_mem_wr_enb, bus.o_mem_rd_enb, bus.o_is_branch,
                          bus.o_rf_wr_enb, bus.o_rf_wr_data_src}, exp_now.ctrl);
    check("rf_wr_addr",  bus.o_rf_wr_addr,     exp_now.waddr);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic bubble_in();
    bus.i_valid = 1'b0; bus.i_rs_data = '0; bus.i_rt_data = '0; bus.i_imm = '0;
    bus.i_shamt = '0; bus.i_pc_plus4 = '0; bus.i_alu_op = '0; bus.i_alu_src = 1'b0;
    {bus.i_mem_wr_enb, bus.i_mem_rd_enb, bus.i_is_branch, bus.i_rf_wr_enb,
     bus.i_rf_wr_data_src} = 5'b0;
    bus.i_rf_wr_addr = '0;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] imm, input logic src, input logic [4:0] sh,
                           input logic [31:0] pc, input logic [4:0] ctrl, input logic [4:0] waddr);
    bus.i_valid = 1'b1; bus.i_alu_op = op; bus.i_rs_data = rs; bus.i_rt_data = rt;
    bus.i_imm = imm; bus.i_alu_src = src; bus.i_shamt = sh; bus.i_pc_plus4 = pc;
    {bus.i_mem_wr_enb, bus.i_mem_rd_enb, bus.i_is_branch, bus.i_rf_wr_enb,
     bus.i_rf_wr_data_src} = ctrl;
    bus.i_rf_wr_addr = waddr;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 5))
      0: w = 32'h0000_0000;
      1: w = 32'hFFFF_FFFF;
      2: w = 32'h8000_0000;
      3: w = 32'($urandom_range(0, 15));
      default: w = $urandom;
    endcase
    return w;
  endfunction

  task automatic rand_instr();
    bus.i_valid      = ($urandom_range(0, 7) != 0);
    bus.i_alu_op     = ($urandom_range(0, 9) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
    bus.i_rs_data    = rand_word();
    bus.i_rt_data    = rand_word();
    bus.i_imm        = rand_word();
    bus.i_alu_src    = 1'($urandom_range(0, 1));
    bus.i_shamt      = 5'($urandom_range(0, 31));
    bus.i_pc_plus4   = $urandom;
    {bus.i_mem_wr_enb, bus.i_mem_rd_enb, bus.i_is_branch, bus.i_rf_wr_enb,
     bus.i_rf_wr_data_src} = 5'($urandom_range(0, 31));
    bus.i_rf_wr_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] waddr,
                        input logic [31:0] product);
    int busy_cnt;
    int bubbles;
    set_instr(4'd11, a, b, 32'd0, 1'b0, 5'd0, 32'd0, 5'b00010, waddr);
    #1;
    check("mul_issue_busy", bus.o_busy, 1'b1);
    busy_cnt = 1;
    bubbles  = 0;
    step();
    bubble_in();
    for (int k = 0; k <= 32; k++) begin
      if (bus.o_busy) busy_cnt++;
      if (!bus.o_rf_wr_enb && bus.o_alu_result == 32'd0) bubbles++;
      step();
    end
    check("mul_busy_cycles", busy_cnt, 33);
    check("mul_bubbles",     bubbles, 33);
    check("mul_result",      bus.o_alu_result, product);
    check("mul_rf_wr_enb",   bus.o_rf_wr_enb, 1'b1);
    check("mul_rf_wr_addr",  bus.o_rf_wr_addr, waddr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   leaks;
    logic frozen;
    i_reset_n   = 1'b0;
    bus.i_flush = 1'b0;
    bubble_in();
    repeat (3) step();
    check("reset_result", bus.o_alu_result, 32'd0);
    check("reset_busy",   bus.o_busy, 1'b0);
    @(posedge i_clock);
    #3 i_reset_n = 1'b1;
    step();

    // ADD with immediate: 5 + (-1) = 4
    set_instr(4'd0, 32'h5, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h0, 5'b00010, 5'd3);
    step(); bubble_in();
    check("add_result", bus.o_alu_result, 32'd4);
    check("add_waddr",  bus.o_rf_wr_addr, 32'd3);
    check("add_wr_enb", bus.o_rf_wr_enb, 1'b1);
    check("add_zero",   bus.o_alu_zero, 1'b0);

    // BEQ as SUB of equal operands
    set_instr(4'd1, 32'h1234, 32'h1234, 32'h10, 1'b0, 5'd0, 32'h100, 5'b00100, 5'd0);
    step(); bubble_in();
    check("beq_zero",      bus.o_alu_zero, 1'b1);
    check("beq_branch",    bus.o_branch_addr, 32'h140);
    check("beq_is_branch", bus.o_is_branch, 1'b1);

    set_instr(4'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd0, 32'h0, 5'b00010, 5'd4);
    step();
    check("slt_signed", bus.o_alu_result, 32'd1);
    set_instr(4'd9, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 5'd4, 32'h0, 5'b00010, 5'd5);
    step(); bubble_in();
    check("sra_signed", bus.o_alu_result, 32'hF800_0000);

    do_mul(32'h0001_0003, 32'h0000_0100, 5'd7, 32'h0100_0300);
    do_mul(32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 32'hFFFF_FFFE);

    // Flush ten cycles into MUL_RUN
    set_instr(4'd11, 32'h3, 32'h5, 32'h0, 1'b0, 5'd0, 32'h0, 5'b00010, 5'd9);
    step(); bubble_in();
    repeat (10) step();
    bus.i_flush = 1'b1;
    #1;
    check("flush_busy_before", bus.o_busy, 1'b1);
    step();
    bus.i_flush = 1'b0;
    check("flush_busy_after", bus.o_busy, 1'b0);
    check("flush_fields", {bus.o_alu_result[7:0], bus.o_rf_wr_enb, bus.o_rf_wr_addr}, 32'd0);
    leaks = 0;
    repeat (40) begin
      if (bus.o_rf_wr_enb || bus.o_alu_result != 32'd0) leaks++;
      step();
    end
    check("flush_no_result", leaks, 0);
    set_instr(4'd0, 32'h7, 32'h8, 32'h0, 1'b0, 5'd0, 32'h0, 5'b00010, 5'd10);
    step(); bubble_in();
    check("post_flush_add", bus.o_alu_result, 32'd15);

    // Reset mid-multiply while ID/EX keeps presenting the MUL
    set_instr(4'd11, 32'h9, 32'h9, 32'h0, 1'b0, 5'd0, 32'h0, 5'b00010, 5'd11);
    repeat (6) step();
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_busy",   bus.o_busy, 1'b0);
    check("rst_result", bus.o_alu_result, 32'd0);
    check("rst_wr_enb", bus.o_rf_wr_enb, 1'b0);
    check("rst_state",  bus.o_dbg_state, ST_IDLE);
    bubble_in();
    step();
    @(posedge i_clock);
    #3 i_reset_n = 1'b1;
    leaks = 0;
    repeat (40) begin
      step();
      if (bus.o_rf_wr_enb || bus.o_alu_result != 32'd0) leaks++;
    end
    check("rst_no_result", leaks, 0);

    // Randomized traffic; upstream holds ID/EX while o_busy was high
    frozen = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!frozen) rand_instr();
      bus.i_flush = ($urandom_range(0, 24) == 0);
      @(negedge i_clock);
      frozen = bus.o_busy;
      step();
    end
    bus.i_flush = 1'b0;
    bubble_in();
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
